// File: rtl/lsu_pkg.sv
// Shared LSU definitions: opcode encodings, access-size codes and the agen entry types
// used by the address generator and its consumers.
package lsu_pkg;

    localparam int SIZE_OPCODE_I = 6;
    localparam int LSU_DATA_W    = 32;
    localparam int LSU_TAG_W     = 7;

    localparam logic [1:0] LDST_SIZE_BYTE  = 2'd0;
    localparam logic [1:0] LDST_SIZE_HALF  = 2'd1;
    localparam logic [1:0] LDST_SIZE_WORD  = 2'd2;
    localparam logic [1:0] LDST_SIZE_OTHER = 2'd3;

    // Memory-op opcodes; every other encoding is treated as unknown (no attributes).
    localparam logic [SIZE_OPCODE_I-1:0] OP_LB    = 6'd1;
    localparam logic [SIZE_OPCODE_I-1:0] OP_LBU   = 6'd2;
    localparam logic [SIZE_OPCODE_I-1:0] OP_LH    = 6'd3;
    localparam logic [SIZE_OPCODE_I-1:0] OP_LHU   = 6'd4;
    localparam logic [SIZE_OPCODE_I-1:0] OP_LW    = 6'd5;
    localparam logic [SIZE_OPCODE_I-1:0] OP_DLW_H = 6'd6;
    localparam logic [SIZE_OPCODE_I-1:0] OP_DLW_L = 6'd7;
    localparam logic [SIZE_OPCODE_I-1:0] OP_L_S   = 6'd8;
    localparam logic [SIZE_OPCODE_I-1:0] OP_L_D   = 6'd9;
    localparam logic [SIZE_OPCODE_I-1:0] OP_LWL   = 6'd10;
    localparam logic [SIZE_OPCODE_I-1:0] OP_LWR   = 6'd11;
    localparam logic [SIZE_OPCODE_I-1:0] OP_SB    = 6'd12;
    localparam logic [SIZE_OPCODE_I-1:0] OP_SH    = 6'd13;
    localparam logic [SIZE_OPCODE_I-1:0] OP_SW    = 6'd14;
    localparam logic [SIZE_OPCODE_I-1:0] OP_DSW_H = 6'd15;
    localparam logic [SIZE_OPCODE_I-1:0] OP_DSW_L = 6'd16;
    localparam logic [SIZE_OPCODE_I-1:0] OP_DSZ   = 6'd17;
    localparam logic [SIZE_OPCODE_I-1:0] OP_S_S   = 6'd18;
    localparam logic [SIZE_OPCODE_I-1:0] OP_S_D   = 6'd19;
    localparam logic [SIZE_OPCODE_I-1:0] OP_SWL   = 6'd20;
    localparam logic [SIZE_OPCODE_I-1:0] OP_SWR   = 6'd21;

    typedef struct packed {
        logic [1:0] size;
        logic       is_load;
        logic       is_store;
        logic       sign_ext;
        logic       dbl_lo;
        logic       misalign;
    } agen_attr_t;

    typedef struct packed {
        logic [LSU_DATA_W-1:0] addr;
        logic [1:0]            size;
        logic                  is_load;
        logic                  is_store;
        logic                  sign_ext;
        logic                  dbl_lo;
        logic                  misalign;
        logic [LSU_TAG_W-1:0]  tag;
    } agen_entry_t;

endpackage

// File: rtl/agen_decode.sv
// Combinational opcode decode and effective-address adder for the agen lane.
// Alignment checking is generated only when AGEN_ALIGN_CHECK_EN is defined.
module agen_decode
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [DATA_W-1:0]        data1,
    input  logic [IMM_W-1:0]         immd,
    input  logic [SIZE_OPCODE_I-1:0] opcode,
    output logic [DATA_W-1:0]        addr,
    output agen_attr_t               attr
);

    logic [DATA_W-1:0] immd_sext;

    assign immd_sext = {{(DATA_W-IMM_W){immd[IMM_W-1]}}, immd};
    assign addr      = data1 + immd_sext;

    always_comb begin
        attr = '0;
        case (opcode)
            OP_LB: begin
                attr.is_load  = 1'b1;
                attr.sign_ext = 1'b1;
                attr.size     = LDST_SIZE_BYTE;
            end
            OP_LBU: begin
                attr.is_load = 1'b1;
                attr.size    = LDST_SIZE_BYTE;
            end
            OP_LH: begin
                attr.is_load  = 1'b1;
                attr.sign_ext = 1'b1;
                attr.size     = LDST_SIZE_HALF;
            end
            OP_LHU: begin
                attr.is_load = 1'b1;
                attr.size    = LDST_SIZE_HALF;
            end
            OP_LW, OP_DLW_H, OP_DLW_L: begin
                attr.is_load = 1'b1;
                attr.dbl_lo  = (opcode == OP_DLW_L);
                attr.size    = LDST_SIZE_WORD;
            end
            OP_L_S, OP_L_D, OP_LWL, OP_LWR: begin
                attr.is_load = 1'b1;
                attr.size    = LDST_SIZE_OTHER;
            end
            OP_SB: begin
                attr.is_store = 1'b1;
                attr.size     = LDST_SIZE_BYTE;
            end
            OP_SH: begin
                attr.is_store = 1'b1;
                attr.size     = LDST_SIZE_HALF;
            end
            OP_SW, OP_DSW_H, OP_DSW_L: begin
                attr.is_store = 1'b1;
                attr.dbl_lo   = (opcode == OP_DSW_L);
                attr.size     = LDST_SIZE_WORD;
            end
            OP_DSZ, OP_S_S, OP_S_D, OP_SWL, OP_SWR: begin
                attr.is_store = 1'b1;
                attr.size     = LDST_SIZE_OTHER;
            end
            default: attr = '0;
        endcase
`ifdef AGEN_ALIGN_CHECK_EN
        // Only half and word accesses can fault; unaligned/other forms are handled by the LSQ.
        attr.misalign = ((attr.size == LDST_SIZE_HALF) && addr[0]) ||
                        ((attr.size == LDST_SIZE_WORD) && (addr[1:0] != 2'b00));
`endif
    end

endmodule

// File: rtl/agen_queue.sv
// Load/store address generator with a DEPTH-entry valid/ready output queue toward the LSQ.
// Optional alignment fault reporting is enabled by defining AGEN_ALIGN_CHECK_EN.
module agen_queue
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int TAG_W  = 7,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_W-1:0]        data1_i,
    input  logic [IMM_W-1:0]         immd_i,
    input  logic [SIZE_OPCODE_I-1:0] opcode_i,
    input  logic [TAG_W-1:0]         tag_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        addr_o,
    output logic [1:0]               ldst_size_o,
    output logic                     is_load_o,
    output logic                     is_store_o,
    output logic                     sign_ext_o,
    output logic                     dbl_lo_o,
    output logic                     misalign_o,
    output logic [TAG_W-1:0]         tag_o
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [DATA_W-1:0] addr_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    agen_attr_t        attr_mem [DEPTH];
    logic [DEPTH-1:0]  wr_sel;
    logic [DATA_W-1:0] dec_addr;
    agen_attr_t        dec_attr;
    logic              push, pop;

    agen_decode #(
        .DATA_W(DATA_W),
        .IMM_W (IMM_W)
    ) u_decode (
        .data1 (data1_i),
        .immd  (immd_i),
        .opcode(opcode_i),
        .addr  (dec_addr),
        .attr  (dec_attr)
    );

    // Handshake depends only on registered count, so in_ready has no path from out_ready.
    assign in_ready_o  = (count_reg != CNT_W'(DEPTH));
    assign out_valid_o = (count_reg != '0);
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // Storage is cleared on reset so every head output reads 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                tag_mem[i]  <= '0;
                attr_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    addr_mem[i] <= dec_addr;
                    tag_mem[i]  <= tag_i;
                    attr_mem[i] <= dec_attr;
                end
            end
        end
    end

    assign addr_o      = addr_mem[rd_ptr_reg];
    assign tag_o       = tag_mem[rd_ptr_reg];
    assign ldst_size_o = attr_mem[rd_ptr_reg].size;
    assign is_load_o   = attr_mem[rd_ptr_reg].is_load;
    assign is_store_o  = attr_mem[rd_ptr_reg].is_store;
    assign sign_ext_o  = attr_mem[rd_ptr_reg].sign_ext;
    assign dbl_lo_o    = attr_mem[rd_ptr_reg].dbl_lo;
    assign misalign_o  = attr_mem[rd_ptr_reg].misalign;

endmodule

// File: tb/tb_agen_queue.sv
// Bench for agen_queue: directed scenarios followed by randomized traffic, all checked
// against a queue-based reference model of the address generator.
module tb_agen_queue;
    import lsu_pkg::*;

    localparam int DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush_i;
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [31:0]              data1_i;
    logic [15:0]              immd_i;
    logic [SIZE_OPCODE_I-1:0] opcode_i;
    logic [6:0]               tag_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [31:0]              addr_o;
    logic [1:0]               ldst_size_o;
    logic                     is_load_o;
    logic                     is_store_o;
    logic                     sign_ext_o;
    logic                     dbl_lo_o;
    logic                     misalign_o;
    logic [6:0]               tag_o;

    int vectors     = 0;
    int miscompares = 0;
    agen_entry_t model_q[$];

    always #5 clk = ~clk;

    agen_queue #(.DATA_W(32), .IMM_W(16), .TAG_W(7), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .data1_i    (data1_i),
        .immd_i     (immd_i),
        .opcode_i   (opcode_i),
        .tag_i      (tag_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .addr_o     (addr_o),
        .ldst_size_o(ldst_size_o),
        .is_load_o  (is_load_o),
        .is_store_o (is_store_o),
        .sign_ext_o (sign_ext_o),
        .dbl_lo_o   (dbl_lo_o),
        .misalign_o (misalign_o),
        .tag_o      (tag_o)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference: classify the opcode by set membership and compute the address arithmetically.
    function automatic agen_entry_t ref_op(input logic [31:0] d1, input logic [15:0] imm,
                                           input logic [SIZE_OPCODE_I-1:0] op, input logic [6:0] tag);
        agen_entry_t e;
        int          disp;
        e        = '0;
        disp     = int'($signed(imm));
        e.addr   = d1 + 32'(disp);
        e.tag    = tag;
        e.is_load  = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_DLW_H, OP_DLW_L,
                                OP_L_S, OP_L_D, OP_LWL, OP_LWR};
        e.is_store = op inside {OP_SB, OP_SH, OP_SW, OP_DSW_H, OP_DSW_L,
                                OP_DSZ, OP_S_S, OP_S_D, OP_SWL, OP_SWR};
        e.sign_ext = op inside {OP_LB, OP_LH};
        e.dbl_lo   = op inside {OP_DLW_L, OP_DSW_L};
        if (op inside {OP_LB, OP_LBU, OP_SB})                                 e.size = 2'd0;
        else if (op inside {OP_LH, OP_LHU, OP_SH})                            e.size = 2'd1;
        else if (op inside {OP_LW, OP_DLW_H, OP_DLW_L, OP_SW, OP_DSW_H, OP_DSW_L}) e.size = 2'd2;
        else if (e.is_load || e.is_store)                                     e.size = 2'd3;
        else                                                                  e.size = 2'd0;
`ifdef AGEN_ALIGN_CHECK_EN
        e.misalign = ((e.size == 2'd1) && (e.addr % 2 != 0)) ||
                     ((e.size == 2'd2) && (e.addr % 4 != 0));
`endif
        return e;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid_o, model_q.size() != 0);
        chk("in_ready", in_ready_o, model_q.size() != DEPTH);
        if (model_q.size() != 0) begin
            chk("addr", addr_o, model_q[0].addr);
            chk("size", ldst_size_o, model_q[0].size);
            chk("is_load", is_load_o, model_q[0].is_load);
            chk("is_store", is_store_o, model_q[0].is_store);
            chk("sign_ext", sign_ext_o, model_q[0].sign_ext);
            chk("dbl_lo", dbl_lo_o, model_q[0].dbl_lo);
            chk("misalign", misalign_o, model_q[0].misalign);
            chk("tag", tag_o, model_q[0].tag);
        end
    endtask

    // One clock cycle: drive at negedge, update the model at posedge, check at next negedge.
    task automatic step(input logic v, input logic rdy, input logic fl,
                        input logic [SIZE_OPCODE_I-1:0] op, input logic [31:0] d1,
                        input logic [15:0] imm, input logic [6:0] tag);
        logic do_push, do_pop;
        in_valid_i  = v;
        out_ready_i = rdy;
        flush_i     = fl;
        opcode_i    = op;
        data1_i     = d1;
        immd_i      = imm;
        tag_i       = tag;
        do_push = v && (model_q.size() < DEPTH) && !fl;
        do_pop  = rdy && (model_q.size() > 0) && !fl;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(ref_op(d1, imm, op, tag));
        end
        @(negedge clk);
        $display("t=%0t push=%0b pop=%0b flush=%0b op=%0d tag=%0d depth=%0d",
                 $time, do_push, do_pop, fl, op, tag, model_q.size());
        check_outputs();
    endtask

    initial begin
        reset = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        data1_i = '0; immd_i = '0; opcode_i = '0; tag_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_addr", addr_o, 0);
        chk("rst_tag", tag_o, 0);
        chk("rst_size", ldst_size_o, 0);
        reset = 1'b0;
        @(negedge clk);

        // LW with negative displacement
        step(1, 0, 0, OP_LW, 32'h0000_1000, 16'hFFFC, 7'd5);
        chk("t1_valid", out_valid_o, 1);
        chk("t1_addr", addr_o, 32'h0000_0FFC);
        chk("t1_size", ldst_size_o, 2);
        chk("t1_load", is_load_o, 1);
        chk("t1_tag", tag_o, 5);
        step(0, 1, 0, '0, '0, '0, '0);

        // LB wrapping past 2^32
        step(1, 0, 0, OP_LB, 32'hFFFF_FFFF, 16'h0001, 7'd9);
        chk("t2_addr", addr_o, 32'h0000_0000);
        chk("t2_sext", sign_ext_o, 1);
        chk("t2_size", ldst_size_o, 0);
        step(0, 1, 0, '0, '0, '0, '0);

        // Fill to DEPTH, refused 5th push, drain in order
        for (int i = 0; i < DEPTH; i++)
            step(1, 0, 0, OP_SW, 32'h2000 + 32'(i * 4), 16'h0, 7'(10 + i));
        chk("t3_full_ready", in_ready_o, 0);
        step(1, 0, 0, OP_SW, 32'h3000, 16'h0, 7'd14);
        chk("t3_still_full", in_ready_o, 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_drain_tag", tag_o, 7'(10 + i));
            step(0, 1, 0, '0, '0, '0, '0);
        end
        chk("t3_empty", out_valid_o, 0);

        // Push+pop with two queued: occupancy unchanged, order kept
        step(1, 0, 0, OP_LH, 32'h100, 16'h2, 7'd20);
        step(1, 0, 0, OP_LHU, 32'h200, 16'h4, 7'd21);
        step(1, 1, 0, OP_SB, 32'h300, 16'h1, 7'd22);
        chk("t4_head", tag_o, 21);
        chk("t4_ready", in_ready_o, 1);
        step(0, 1, 0, '0, '0, '0, '0);
        chk("t4_next", tag_o, 22);
        step(0, 1, 0, '0, '0, '0, '0);

        // Alignment
        step(1, 0, 0, OP_SH, 32'h1000, 16'h0001, 7'd30);
`ifdef AGEN_ALIGN_CHECK_EN
        chk("t5_sh_misalign", misalign_o, 1);
`else
        chk("t5_sh_misalign", misalign_o, 0);
`endif
        step(0, 1, 0, '0, '0, '0, '0);
        step(1, 0, 0, OP_SWL, 32'h1000, 16'h0003, 7'd31);
        chk("t5_swl_misalign", misalign_o, 0);
        chk("t5_swl_size", ldst_size_o, 3);
        step(0, 1, 0, '0, '0, '0, '0);

        // Flush with a same-cycle input
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, OP_LBU, 32'h40, 16'(i), 7'(35 + i));
        step(1, 0, 1, OP_LW, 32'h80, 16'h0, 7'd40);
        chk("t6_valid", out_valid_o, 0);
        chk("t6_ready", in_ready_o, 1);
        step(0, 1, 0, '0, '0, '0, '0);
        step(1, 0, 0, OP_DLW_L, 32'h500, 16'h8, 7'd41);
        chk("t6_after_tag", tag_o, 41);
        chk("t6_dbl_lo", dbl_lo_o, 1);

        // Asynchronous reset mid-operation
        step(1, 0, 0, OP_SW, 32'h600, 16'h0, 7'd42);
        reset = 1'b1;
        #1;
        model_q.delete();
        chk("async_rst_valid", out_valid_o, 0);
        chk("async_rst_ready", in_ready_o, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Randomized traffic including unknown opcodes and occasional flushes
        for (int n = 0; n < 400; n++)
            step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 32) == 0,
                 SIZE_OPCODE_I'($urandom % 32), $urandom, 16'($urandom), 7'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
